// File: rtl/den_gt_mon.sv
`default_nettype none
// ------------------------------------------------------------------------
// den_gt_mon - two-road traffic-light lamp monitor (phase, sequence, dwell)
// Rev 1.0
// ------------------------------------------------------------------------
module den_gt_mon #(
  parameter int unsigned YEL_CYC = 3,
  parameter int unsigned GRN_MIN = 5,
  parameter int unsigned GRN_MAX = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  light,
  input  logic        chk_en,
  input  logic        clr_err,
  output logic        err_onehot,
  output logic        err_conflict,
  output logic        err_seq,
  output logic        err_time,
  output logic        err_any,
  output logic [2:0]  phase,
  output logic [15:0] cycle_cnt
);

  typedef enum logic [2:0] {
    SYNC = 3'd0,
    AG   = 3'd1,
    AY   = 3'd2,
    RA   = 3'd3,
    BG   = 3'd4,
    BY   = 3'd5,
    RB   = 3'd6
  } phase_e;

  localparam logic [5:0] c_PAT_AG = 6'b001100;
  localparam logic [5:0] c_PAT_AY = 6'b010100;
  localparam logic [5:0] c_PAT_RR = 6'b100100;
  localparam logic [5:0] c_PAT_BG = 6'b100001;
  localparam logic [5:0] c_PAT_BY = 6'b100010;

  localparam logic [7:0] c_YEL_CYC  = 8'(YEL_CYC);
  localparam logic [7:0] c_GRN_MIN  = 8'(GRN_MIN);
  localparam logic [7:0] c_GRN_OVER = 8'(GRN_MAX + 1);

  function automatic logic is_onehot3(input logic [2:0] v);
    return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
  endfunction

  logic [5:0]  light_q;
  phase_e      phase_q, phase_d;
  logic [7:0]  dwell_q, dwell_d;
  logic        timed_q, timed_d;
  logic [15:0] cnt_q, cnt_d;
  logic        err_onehot_q, err_onehot_d;
  logic        err_conflict_q, err_conflict_d;
  logic        err_seq_q, err_seq_d;
  logic        err_time_q, err_time_d;
  logic        err_any_q;

  logic        w_fields_ok;
  logic        w_conflict;
  logic [5:0]  w_cur_pat;
  logic [7:0]  w_dwell_inc;
  logic        w_is_green;
  logic        w_is_yellow;
  logic        ev_onehot, ev_conflict, ev_seq, ev_time;
  logic        legal;
  logic        bump_cnt;
  phase_e      target;

  assign w_fields_ok = is_onehot3(light_q[5:3]) && is_onehot3(light_q[2:0]);
  assign w_conflict  = w_fields_ok && !light_q[5] && !light_q[2];
  assign w_dwell_inc = (dwell_q == 8'hFF) ? 8'hFF : dwell_q + 8'd1;
  assign w_is_green  = (phase_q == AG) || (phase_q == BG);
  assign w_is_yellow = (phase_q == AY) || (phase_q == BY);

  always_comb begin
    w_cur_pat = 6'b000000;
    unique case (phase_q)
      AG:      w_cur_pat = c_PAT_AG;
      AY:      w_cur_pat = c_PAT_AY;
      RA, RB:  w_cur_pat = c_PAT_RR;
      BG:      w_cur_pat = c_PAT_BG;
      BY:      w_cur_pat = c_PAT_BY;
      default: w_cur_pat = 6'b000000;
    endcase
  end

  always_comb begin
    phase_d     = phase_q;
    timed_d     = timed_q;
    cnt_d       = cnt_q;
    ev_onehot   = 1'b0;
    ev_conflict = 1'b0;
    ev_seq      = 1'b0;
    ev_time     = 1'b0;
    legal       = 1'b0;
    bump_cnt    = 1'b0;
    target      = phase_q;

    if (!w_fields_ok) begin
      ev_onehot = 1'b1;
      phase_d   = SYNC;
      timed_d   = 1'b0;
    end else if (w_conflict) begin
      ev_conflict = 1'b1;
      phase_d     = SYNC;
      timed_d     = 1'b0;
    end else if (phase_q == SYNC) begin
      // The first green after sync has unknown history, so it goes untimed.
      if (light_q == c_PAT_AG) phase_d = AG;
      else if (light_q == c_PAT_BG) phase_d = BG;
      timed_d = 1'b0;
    end else if (light_q != w_cur_pat) begin
      unique case (phase_q)
        AG: if (light_q == c_PAT_AY) begin legal = 1'b1; target = AY; end
        AY: begin
          if (light_q == c_PAT_RR) begin legal = 1'b1; target = RA; end
          else if (light_q == c_PAT_BG) begin legal = 1'b1; target = BG; end
        end
        RA: if (light_q == c_PAT_BG) begin legal = 1'b1; target = BG; end
        BG: if (light_q == c_PAT_BY) begin legal = 1'b1; target = BY; end
        BY: begin
          if (light_q == c_PAT_RR) begin legal = 1'b1; target = RB; end
          else if (light_q == c_PAT_AG) begin
            legal = 1'b1; target = AG; bump_cnt = 1'b1;
          end
        end
        RB: if (light_q == c_PAT_AG) begin
          legal = 1'b1; target = AG; bump_cnt = 1'b1;
        end
        default: legal = 1'b0;
      endcase

      if (timed_q && w_is_green && (dwell_q < c_GRN_MIN)) ev_time = 1'b1;
      if (w_is_yellow && (dwell_q != c_YEL_CYC)) ev_time = 1'b1;

      if (legal) begin
        phase_d = target;
        timed_d = 1'b1;
        if (bump_cnt) cnt_d = cnt_q + 16'd1;
      end else begin
        ev_seq  = 1'b1;
        timed_d = 1'b0;
        if (light_q == c_PAT_AG) phase_d = AG;
        else if (light_q == c_PAT_BG) phase_d = BG;
        else phase_d = SYNC;
      end
    end else begin
      // Over-long green fires exactly once, when the count crosses the limit.
      if (timed_q && w_is_green && (dwell_q != 8'hFF) && (w_dwell_inc == c_GRN_OVER))
        ev_time = 1'b1;
    end

    dwell_d = (phase_d != phase_q) ? 8'd1 : w_dwell_inc;
  end

  assign err_onehot_d   = (err_onehot_q   & ~clr_err) | (chk_en & ev_onehot);
  assign err_conflict_d = (err_conflict_q & ~clr_err) | (chk_en & ev_conflict);
  assign err_seq_d      = (err_seq_q      & ~clr_err) | (chk_en & ev_seq);
  assign err_time_d     = (err_time_q     & ~clr_err) | (chk_en & ev_time);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      light_q        <= 6'b000000;
      phase_q        <= SYNC;
      dwell_q        <= 8'd0;
      timed_q        <= 1'b0;
      cnt_q          <= 16'd0;
      err_onehot_q   <= 1'b0;
      err_conflict_q <= 1'b0;
      err_seq_q      <= 1'b0;
      err_time_q     <= 1'b0;
      err_any_q      <= 1'b0;
    end else begin
      light_q        <= light;
      phase_q        <= phase_d;
      dwell_q        <= dwell_d;
      timed_q        <= timed_d;
      cnt_q          <= cnt_d;
      err_onehot_q   <= err_onehot_d;
      err_conflict_q <= err_conflict_d;
      err_seq_q      <= err_seq_d;
      err_time_q     <= err_time_d;
      err_any_q      <= err_onehot_d | err_conflict_d | err_seq_d | err_time_d;
    end
  end

  assign err_onehot   = err_onehot_q;
  assign err_conflict = err_conflict_q;
  assign err_seq      = err_seq_q;
  assign err_time     = err_time_q;
  assign err_any      = err_any_q;
  assign phase        = phase_q;
  assign cycle_cnt    = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_den_gt_mon.sv
`default_nettype none
// ------------------------------------------------------------------------
// tb_den_gt_mon - directed vector table plus reset sequences for den_gt_mon
// Rev 1.0
// ------------------------------------------------------------------------
module tb_den_gt_mon;

  localparam logic [5:0] L_AG   = 6'b001100;
  localparam logic [5:0] L_AY   = 6'b010100;
  localparam logic [5:0] L_BG   = 6'b100001;
  localparam logic [5:0] L_BY   = 6'b100010;
  localparam logic [5:0] L_CONF = 6'b001001;
  localparam logic [5:0] L_BAD  = 6'b011100;

  typedef struct {
    logic [5:0]  lt;
    logic        chk;
    logic        clr;
    int          n;
    logic [2:0]  ph;
    logic [4:0]  fl;   // {any, onehot, conflict, seq, time}
    logic [15:0] cnt;
  } vec_t;

  logic        clk;
  logic        reset;
  logic [5:0]  light;
  logic        chk_en;
  logic        clr_err;
  logic        err_onehot, err_conflict, err_seq, err_time, err_any;
  logic [2:0]  phase;
  logic [15:0] cycle_cnt;

  int checks = 0;
  int errors = 0;

  vec_t tab1[$];
  vec_t tab2[$];

  den_gt_mon #(.YEL_CYC(3), .GRN_MIN(5), .GRN_MAX(20)) dut (
    .clk          (clk),
    .reset        (reset),
    .light        (light),
    .chk_en       (chk_en),
    .clr_err      (clr_err),
    .err_onehot   (err_onehot),
    .err_conflict (err_conflict),
    .err_seq      (err_seq),
    .err_time     (err_time),
    .err_any      (err_any),
    .phase        (phase),
    .cycle_cnt    (cycle_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input logic [5:0] lt, input logic chk, input logic clr,
                              input int n, input logic [2:0] ph, input logic [4:0] fl,
                              input logic [15:0] cnt);
    vec_t v;
    v.lt = lt; v.chk = chk; v.clr = clr; v.n = n;
    v.ph = ph; v.fl = fl; v.cnt = cnt;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [15:0] act,
                       input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input int idx, input logic [2:0] ph,
                               input logic [4:0] fl, input logic [15:0] cnt);
    check({tag, ".phase"}, idx, 16'(phase), 16'(ph));
    check({tag, ".flags"}, idx,
          16'({err_any, err_onehot, err_conflict, err_seq, err_time}), 16'(fl));
    check({tag, ".cycle_cnt"}, idx, cycle_cnt, cnt);
  endtask

  task automatic run_vec(input vec_t v, input string tag, input int idx);
    light   = v.lt;
    chk_en  = v.chk;
    clr_err = v.clr;
    repeat (v.n) begin
      @(posedge clk);
      #1;
    end
    check_outputs(tag, idx, v.ph, v.fl, v.cnt);
  endtask

  initial begin
    // Nominal cycle: first AG comes from SYNC, so it does not count.
    tab1.push_back(mk(L_AG, 0, 0, 1, 3'd0, 5'b00000, 16'd0));
    tab1.push_back(mk(L_AG, 1, 0, 9, 3'd1, 5'b00000, 16'd0));
    for (int r = 0; r < 3; r++) begin
      if (r > 0) tab1.push_back(mk(L_AG, 1, 0, 10, 3'd1, 5'b00000, 16'(r)));
      tab1.push_back(mk(L_AY, 1, 0, 3,  3'd2, 5'b00000, 16'(r)));
      tab1.push_back(mk(L_BG, 1, 0, 10, 3'd4, 5'b00000, 16'(r)));
      tab1.push_back(mk(L_BY, 1, 0, 3,  3'd5, 5'b00000, 16'(r)));
    end
    // One-cycle conflict, then clear.
    tab1.push_back(mk(L_CONF, 1, 0, 1, 3'd5, 5'b00000, 16'd2));
    tab1.push_back(mk(L_AG,   1, 0, 1, 3'd0, 5'b10100, 16'd2));
    tab1.push_back(mk(L_AG,   1, 0, 1, 3'd1, 5'b10100, 16'd2));
    tab1.push_back(mk(L_AG,   0, 1, 1, 3'd1, 5'b00000, 16'd2));
    // AG straight to BG: sequence error, resync into BG.
    tab1.push_back(mk(L_AG,   1, 0, 6, 3'd1, 5'b00000, 16'd2));
    tab1.push_back(mk(L_BG,   1, 0, 2, 3'd4, 5'b10010, 16'd2));
    tab1.push_back(mk(L_BG,   1, 1, 1, 3'd4, 5'b00000, 16'd2));
    // Resynced BG is untimed, so its short dwell exits cleanly.
    tab1.push_back(mk(L_BY,   1, 0, 3, 3'd5, 5'b00000, 16'd2));
    // Over-long green: flag lands exactly when dwell reaches 21.
    tab1.push_back(mk(L_AG,   1, 0, 21, 3'd1, 5'b00000, 16'd3));
    tab1.push_back(mk(L_AG,   1, 0, 1,  3'd1, 5'b10001, 16'd3));
    tab1.push_back(mk(L_AG,   1, 0, 4,  3'd1, 5'b10001, 16'd3));
    tab1.push_back(mk(L_BAD,  1, 0, 1,  3'd1, 5'b10001, 16'd3));
    tab1.push_back(mk(L_AG,   1, 0, 1,  3'd0, 5'b11001, 16'd3));
    // Clear without checking, then short yellow exit coincident with clear.
    tab1.push_back(mk(L_AG,   0, 1, 1, 3'd1, 5'b00000, 16'd3));
    tab1.push_back(mk(L_AY,   1, 0, 2, 3'd2, 5'b00000, 16'd3));
    tab1.push_back(mk(L_BG,   1, 0, 1, 3'd2, 5'b00000, 16'd3));
    tab1.push_back(mk(L_BG,   1, 1, 1, 3'd4, 5'b10001, 16'd3));
    // Two more clean cycles to reach cycle_cnt = 5, stopping mid-BG.
    tab1.push_back(mk(L_BG,   1, 1, 6, 3'd4, 5'b00000, 16'd3));
    tab1.push_back(mk(L_BY,   1, 0, 3, 3'd5, 5'b00000, 16'd3));
    tab1.push_back(mk(L_AG,   1, 0, 5, 3'd1, 5'b00000, 16'd4));
    tab1.push_back(mk(L_AY,   1, 0, 3, 3'd2, 5'b00000, 16'd4));
    tab1.push_back(mk(L_BG,   1, 0, 5, 3'd4, 5'b00000, 16'd4));
    tab1.push_back(mk(L_BY,   1, 0, 3, 3'd5, 5'b00000, 16'd4));
    tab1.push_back(mk(L_AG,   1, 0, 5, 3'd1, 5'b00000, 16'd5));
    tab1.push_back(mk(L_AY,   1, 0, 3, 3'd2, 5'b00000, 16'd5));
    tab1.push_back(mk(L_BG,   1, 0, 3, 3'd4, 5'b00000, 16'd5));

    // After mid-BG reset: first BG untimed, then a timed short green.
    tab2.push_back(mk(L_BG,   0, 0, 1, 3'd0, 5'b00000, 16'd0));
    tab2.push_back(mk(L_BG,   1, 0, 3, 3'd4, 5'b00000, 16'd0));
    tab2.push_back(mk(L_BY,   1, 0, 3, 3'd5, 5'b00000, 16'd0));
    tab2.push_back(mk(L_AG,   1, 0, 4, 3'd1, 5'b00000, 16'd1));
    tab2.push_back(mk(L_AY,   1, 0, 2, 3'd2, 5'b10001, 16'd1));
    tab2.push_back(mk(L_AY,   1, 1, 1, 3'd2, 5'b00000, 16'd1));
    tab2.push_back(mk(L_CONF, 0, 0, 2, 3'd0, 5'b00000, 16'd1));

    reset   = 1'b0;
    light   = L_AG;
    chk_en  = 1'b0;
    clr_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset", 0, 3'd0, 5'b00000, 16'd0);
    reset = 1'b1;

    for (int i = 0; i < tab1.size(); i++) run_vec(tab1[i], "t1", i);

    // Asynchronous reset mid-BG: outputs must drop before any clock edge.
    #2;
    reset = 1'b0;
    #1;
    check_outputs("midreset", 0, 3'd0, 5'b00000, 16'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    for (int i = 0; i < tab2.size(); i++) run_vec(tab2[i], "t2", i);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/den_gt_mon.md
DEN_GT_MON -- requirements
Module: den_gt_mon

Interface
REQ-001 SHALL have parameter YEL_CYC, default 3: required yellow dwell, in clk cycles.
REQ-002 SHALL have parameter GRN_MIN, default 5: minimum green dwell, in clk cycles.
REQ-003 SHALL have parameter GRN_MAX, default 20: maximum green dwell, in clk cycles.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port light, input, 6 bits: observed lamps. [5:3] = road A {red, yellow, green}; [2:0] = road B {red, yellow, green}.
REQ-007 SHALL have port chk_en, input, 1 bit: when 1, error flags may set.
REQ-008 SHALL have port clr_err, input, 1 bit: synchronous clear of the sticky error flags.
REQ-009 SHALL have output ports err_onehot, err_conflict, err_seq and err_time, 1 bit each: sticky error flags.
REQ-010 SHALL have port err_any, output, 1 bit: OR of the four error flags, registered.
REQ-011 SHALL have port phase, output, 3 bits: tracked phase code.
REQ-012 SHALL have port cycle_cnt, output, 16 bits: count of completed signal cycles.

Function
REQ-013 SHALL register light into light_q every cycle; all checks SHALL use light_q, and flags SHALL update on the following edge (2-edge latency from light).
REQ-014 SHALL use phase codes SYNC=0, AG=1 (001100), AY=2 (010100), RA=3 (100100 after AY), BG=4 (100001), BY=5 (100010), RB=6 (100100 after BY).
REQ-015 SHALL accept only these legal transitions: AG->AY, AY->RA, AY->BG, RA->BG, BG->BY, BY->RB, BY->AG, RB->AG; an unchanged pattern holds the phase.
REQ-016 In SYNC, SHALL enter AG or BG on the first matching pattern, ignore all other valid patterns without error, and skip the timing check for that first green.
REQ-017 SHALL set err_onehot when either 3-bit road field of light_q is not one-hot, and go to SYNC.
REQ-018 SHALL set err_conflict when both fields are one-hot but neither is red, and go to SYNC.
REQ-019 SHALL set err_seq on any valid pattern change that is not a legal transition, then resync: go to AG/BG if the new pattern is a green, else SYNC.
REQ-020 SHALL maintain an 8-bit dwell counter, reset to 1 on each phase entry and incremented each cycle held, saturating at 255.
REQ-021 SHALL set err_time when a green is exited with dwell < GRN_MIN, on the cycle a green's dwell reaches GRN_MAX+1 (flag once per phase), or when a yellow is exited with dwell != YEL_CYC.
REQ-022 SHALL raise a flag only when chk_en=1 in the evaluating cycle; phase tracking SHALL run regardless of chk_en.
REQ-023 SHALL keep flags set until clr_err or reset; if clr_err coincides with a new error, the flag SHALL be set (set wins).
REQ-024 SHALL increment cycle_cnt by 1 on each legal entry into AG from BY or RB, wrapping 0xFFFF->0; cycle_cnt SHALL NOT be cleared by clr_err.
REQ-025 SHALL continue tracking after errors; simultaneous onehot and conflict SHALL NOT occur, because one-hot failure takes precedence.

Reset
REQ-026 On reset=0, asynchronously: light_q=0, phase=SYNC, dwell=0, all error flags=0, err_any=0, cycle_cnt=0.
REQ-027 Reset asserted mid-phase SHALL discard dwell history; after release, the first green SHALL be untimed per REQ-016.

Verification
REQ-028 Reset release, then AG 10 / AY 3 / BG 10 / BY 3 repeated 3 times, chk_en=1 -> no flags; cycle_cnt=2 after the 3rd AG entry (the first AG is entered from SYNC); phase follows 1,2,4,5.
REQ-029 light=001001 for 1 cycle -> err_conflict=1 and err_any=1 two edges later; phase=0.
REQ-030 AG -> BG directly after 8 cycles -> err_seq=1; phase=4; err_time=0.
REQ-031 AG held 25 cycles (GRN_MAX=20) -> err_time=1 when dwell reaches 21; light 011100 -> err_onehot=1.
REQ-032 Error present, then clr_err=1 with chk_en=0 -> all flags 0; clr_err coincident with a new AY dwell=2 exit -> err_time stays 1.
REQ-033 Reset pulsed low mid-BG with cycle_cnt=5 -> all outputs 0 immediately; next BG is untimed, with no err_time.
